// File: rtl/stg_ex.sv
// stg_ex: execute stage that resolves conditional branches and owns the three 12-bit uimm banks
`ifndef HBIT_ADDR
`define HBIT_ADDR 47
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 23
`endif
`ifndef HBIT_OPC
`define HBIT_OPC 7
`endif
`ifndef HBIT_CC
`define HBIT_CC 3
`endif
`ifndef HBIT_TGT_GP
`define HBIT_TGT_GP 3
`endif
`ifndef HBIT_TGT_SR
`define HBIT_TGT_SR 1
`endif
`ifndef HBIT_TGT_AR
`define HBIT_TGT_AR 1
`endif
`ifndef HBIT_SRC_GP
`define HBIT_SRC_GP 3
`endif
`ifndef HBIT_SRC_SR
`define HBIT_SRC_SR 1
`endif
`ifndef HBIT_SRC_AR
`define HBIT_SRC_AR 1
`endif
`ifndef OPC_NOP
`define OPC_NOP   8'h00
`define OPC_LUIui 8'h10
`define OPC_JCCui 8'h11
`define OPC_BCCsr 8'h12
`define OPC_BCCso 8'h13
`define OPC_BALso 8'h14
`endif
`ifndef CC_AL
`define CC_AL 4'd0
`define CC_EQ 4'd1
`define CC_NE 4'd2
`define CC_LT 4'd3
`define CC_GE 4'd4
`define CC_LE 4'd5
`define CC_GT 4'd6
`define CC_BT 4'd7
`define CC_AE 4'd8
`define CC_BE 4'd9
`define CC_AT 4'd10
`endif

module stg_ex (
  input  logic                    iw_clk,
  input  logic                    iw_rst,
  input  logic [`HBIT_ADDR:0]     iw_pc,
  output logic [`HBIT_ADDR:0]     ow_pc,
  input  logic [`HBIT_DATA:0]     iw_instr,
  output logic [`HBIT_DATA:0]     ow_instr,
  input  logic [`HBIT_OPC:0]      iw_opc,
  output logic [`HBIT_OPC:0]      ow_opc,
  input  logic                    iw_sgn_en,
  input  logic                    iw_imm_en,
  input  logic [15:0]             iw_imm16_val,
  input  logic [13:0]             iw_imm14_val,
  input  logic [11:0]             iw_imm12_val,
  input  logic [9:0]              iw_imm10_val,
  input  logic [`HBIT_CC:0]       iw_cc,
  input  logic [`HBIT_TGT_GP:0]   iw_tgt_gp,
  input  logic                    iw_tgt_gp_we,
  output logic [`HBIT_TGT_GP:0]   ow_tgt_gp,
  output logic                    ow_tgt_gp_we,
  input  logic [`HBIT_TGT_SR:0]   iw_tgt_sr,
  input  logic                    iw_tgt_sr_we,
  output logic [`HBIT_TGT_SR:0]   ow_tgt_sr,
  output logic                    ow_tgt_sr_we,
  input  logic [`HBIT_TGT_AR:0]   iw_tgt_ar,
  output logic [`HBIT_TGT_AR:0]   ow_tgt_ar,
  output logic                    ow_tgt_ar_we,
  input  logic [`HBIT_SRC_GP:0]   iw_src_gp,
  input  logic [`HBIT_SRC_AR:0]   iw_src_ar,
  input  logic [`HBIT_SRC_SR:0]   iw_src_sr,
  input  logic [`HBIT_DATA:0]     iw_src_gp_val,
  input  logic [`HBIT_DATA:0]     iw_tgt_gp_val,
  input  logic [`HBIT_ADDR:0]     iw_src_ar_val,
  input  logic [`HBIT_ADDR:0]     iw_tgt_ar_val,
  input  logic [`HBIT_ADDR:0]     iw_src_sr_val,
  input  logic [`HBIT_ADDR:0]     iw_tgt_sr_val,
  output logic [`HBIT_ADDR:0]     ow_addr,
  output logic [`HBIT_DATA:0]     ow_result,
  output logic [`HBIT_ADDR:0]     ow_ar_result,
  output logic [`HBIT_ADDR:0]     ow_sr_result,
  output logic                    ow_branch_taken,
  output logic [`HBIT_ADDR:0]     ow_branch_pc,
  input  logic                    iw_flush,
  input  logic                    iw_stall
);
  logic [11:0] bank0, bank1, bank2;
  logic z, n, c, v, cond;
  logic is_lui, is_jcc, is_bsr, is_bso, is_bal, taken_d;
  logic [`HBIT_ADDR:0] tgt_d;
  logic unused;
  assign unused = ^{iw_sgn_en, iw_imm_en, iw_imm14_val, iw_imm10_val, iw_src_gp, iw_src_ar, iw_src_sr, iw_tgt_sr_val};
  assign {v, c, n, z} = iw_src_sr_val[3:0];
  assign is_lui = iw_opc == `OPC_LUIui;
  assign is_jcc = iw_opc == `OPC_JCCui;
  assign is_bsr = iw_opc == `OPC_BCCsr;
  assign is_bso = iw_opc == `OPC_BCCso;
  assign is_bal = iw_opc == `OPC_BALso;
  // C is treated as a borrow flag, so "below" means C set
  always_comb begin
    cond = (iw_cc == `CC_AL) ? 1'b1 :
           (iw_cc == `CC_EQ) ? z :
           (iw_cc == `CC_NE) ? !z :
           (iw_cc == `CC_LT) ? (n != v) :
           (iw_cc == `CC_GE) ? (n == v) :
           (iw_cc == `CC_LE) ? (z || (n != v)) :
           (iw_cc == `CC_GT) ? (!z && (n == v)) :
           (iw_cc == `CC_BT) ? c :
           (iw_cc == `CC_AE) ? !c :
           (iw_cc == `CC_BE) ? (c || z) :
           (iw_cc == `CC_AT) ? (!c && !z) : 1'b0;
    taken_d = is_bal || ((is_jcc || is_bsr || is_bso) && cond);
    tgt_d = is_jcc ? {bank2, bank1, bank0, iw_imm12_val} :
            is_bsr ? iw_pc + {{24{iw_tgt_gp_val[23]}}, iw_tgt_gp_val} :
            is_bso ? iw_pc + {{36{iw_imm12_val[11]}}, iw_imm12_val} :
                     iw_pc + {{32{iw_imm16_val[15]}}, iw_imm16_val};
  end
  always_ff @(posedge iw_clk) begin
    if (!iw_rst || iw_flush) begin
      ow_pc           <= '0;
      ow_instr        <= '0;
      ow_opc          <= '0;
      ow_tgt_gp       <= '0;
      ow_tgt_gp_we    <= 1'b0;
      ow_tgt_sr       <= '0;
      ow_tgt_sr_we    <= 1'b0;
      ow_tgt_ar       <= '0;
      ow_tgt_ar_we    <= 1'b0;
      ow_addr         <= '0;
      ow_result       <= '0;
      ow_ar_result    <= '0;
      ow_sr_result    <= '0;
      ow_branch_taken <= 1'b0;
      ow_branch_pc    <= '0;
    end else if (!iw_stall) begin
      ow_pc           <= iw_pc;
      ow_instr        <= iw_instr;
      ow_opc          <= iw_opc;
      ow_tgt_gp       <= iw_tgt_gp;
      ow_tgt_gp_we    <= iw_tgt_gp_we;
      ow_tgt_sr       <= iw_tgt_sr;
      ow_tgt_sr_we    <= iw_tgt_sr_we;
      ow_tgt_ar       <= iw_tgt_ar;
      ow_tgt_ar_we    <= 1'b0;
      ow_addr         <= iw_tgt_ar_val;
      ow_result       <= iw_src_gp_val;
      ow_ar_result    <= iw_src_ar_val;
      ow_sr_result    <= iw_src_sr_val;
      ow_branch_taken <= taken_d;
      ow_branch_pc    <= taken_d ? tgt_d : '0;
    end
  end
  // banks survive flush; only reset clears them and only an unstalled LUIui writes them
  always_ff @(posedge iw_clk) begin
    if (!iw_rst) begin
      bank0 <= '0;
      bank1 <= '0;
      bank2 <= '0;
    end else if (!iw_flush && !iw_stall && is_lui) begin
      bank0 <= (iw_instr[15:14] == 2'b00) ? iw_imm12_val : bank0;
      bank1 <= (iw_instr[15:14] == 2'b01) ? iw_imm12_val : bank1;
      bank2 <= (iw_instr[15:14] == 2'b10) ? iw_imm12_val : bank2;
    end
  end
endmodule

// File: tb/tb_stg_ex.sv
// tb_stg_ex: directed self-checking bench for the stg_ex execute stage
`ifndef OPC_NOP
`define OPC_NOP   8'h00
`define OPC_LUIui 8'h10
`define OPC_JCCui 8'h11
`define OPC_BCCsr 8'h12
`define OPC_BCCso 8'h13
`define OPC_BALso 8'h14
`endif
`ifndef CC_AL
`define CC_AL 4'd0
`define CC_EQ 4'd1
`define CC_NE 4'd2
`define CC_LT 4'd3
`define CC_GE 4'd4
`define CC_LE 4'd5
`define CC_GT 4'd6
`define CC_BT 4'd7
`define CC_AE 4'd8
`define CC_BE 4'd9
`define CC_AT 4'd10
`endif

module tb_stg_ex;
  logic clk = 1'b0, rst;
  logic [47:0] pc, ow_pc;
  logic [23:0] instr, ow_instr;
  logic [7:0]  opc, ow_opc;
  logic sgn_en, imm_en;
  logic [15:0] imm16;
  logic [13:0] imm14;
  logic [11:0] imm12;
  logic [9:0]  imm10;
  logic [3:0]  cc;
  logic [3:0]  tgt_gp, ow_tgt_gp;
  logic tgt_gp_we, ow_tgt_gp_we, tgt_sr_we, ow_tgt_sr_we, ow_tgt_ar_we;
  logic [1:0]  tgt_sr, ow_tgt_sr, tgt_ar, ow_tgt_ar;
  logic [3:0]  src_gp;
  logic [1:0]  src_ar, src_sr;
  logic [23:0] src_gp_val, tgt_gp_val, ow_result;
  logic [47:0] src_ar_val, tgt_ar_val, src_sr_val, tgt_sr_val;
  logic [47:0] ow_addr, ow_ar_result, ow_sr_result, ow_branch_pc;
  logic ow_branch_taken, flush, stall;
  int n_cmp = 0, n_err = 0;

  stg_ex dut (
    .iw_clk(clk), .iw_rst(rst), .iw_pc(pc), .ow_pc(ow_pc),
    .iw_instr(instr), .ow_instr(ow_instr), .iw_opc(opc), .ow_opc(ow_opc),
    .iw_sgn_en(sgn_en), .iw_imm_en(imm_en),
    .iw_imm16_val(imm16), .iw_imm14_val(imm14), .iw_imm12_val(imm12), .iw_imm10_val(imm10),
    .iw_cc(cc),
    .iw_tgt_gp(tgt_gp), .iw_tgt_gp_we(tgt_gp_we), .ow_tgt_gp(ow_tgt_gp), .ow_tgt_gp_we(ow_tgt_gp_we),
    .iw_tgt_sr(tgt_sr), .iw_tgt_sr_we(tgt_sr_we), .ow_tgt_sr(ow_tgt_sr), .ow_tgt_sr_we(ow_tgt_sr_we),
    .iw_tgt_ar(tgt_ar), .ow_tgt_ar(ow_tgt_ar), .ow_tgt_ar_we(ow_tgt_ar_we),
    .iw_src_gp(src_gp), .iw_src_ar(src_ar), .iw_src_sr(src_sr),
    .iw_src_gp_val(src_gp_val), .iw_tgt_gp_val(tgt_gp_val),
    .iw_src_ar_val(src_ar_val), .iw_tgt_ar_val(tgt_ar_val),
    .iw_src_sr_val(src_sr_val), .iw_tgt_sr_val(tgt_sr_val),
    .ow_addr(ow_addr), .ow_result(ow_result), .ow_ar_result(ow_ar_result), .ow_sr_result(ow_sr_result),
    .ow_branch_taken(ow_branch_taken), .ow_branch_pc(ow_branch_pc),
    .iw_flush(flush), .iw_stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rst = 1'b1; pc = '0; instr = '0; opc = `OPC_NOP; sgn_en = 1'b0; imm_en = 1'b0;
    imm16 = '0; imm14 = '0; imm12 = '0; imm10 = '0; cc = `CC_AL;
    tgt_gp = '0; tgt_gp_we = 1'b0; tgt_sr = '0; tgt_sr_we = 1'b0; tgt_ar = '0;
    src_gp = '0; src_ar = '0; src_sr = '0; src_gp_val = '0; tgt_gp_val = '0;
    src_ar_val = '0; tgt_ar_val = '0; src_sr_val = '0; tgt_sr_val = '0;
    flush = 1'b0; stall = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lui(input logic [1:0] sel, input logic [11:0] v);
    clr(); opc = `OPC_LUIui; instr = {8'h00, sel, 14'h0}; imm12 = v; step();
  endtask

  initial begin
    clr();
    rst = 1'b0; opc = `OPC_BALso; pc = 48'h1000; imm16 = 16'd4; tgt_gp_we = 1'b1; src_gp_val = 24'h123456;
    step();
    chk("rst_taken", ow_branch_taken, 0);
    chk("rst_bpc", ow_branch_pc, 0);
    chk("rst_pc", ow_pc, 0);
    chk("rst_we", ow_tgt_gp_we, 0);
    chk("rst_result", ow_result, 0);
    lui(2'b10, 12'h012);
    chk("lui_opc", ow_opc, `OPC_LUIui);
    chk("lui_taken", ow_branch_taken, 0);
    lui(2'b01, 12'h345);
    lui(2'b00, 12'h678);
    lui(2'b11, 12'hEEE);
    clr(); opc = `OPC_JCCui; cc = `CC_EQ; src_sr_val = 48'h1; imm12 = 12'h9AB; step();
    chk("jcc_taken", ow_branch_taken, 1);
    chk("jcc_pc", ow_branch_pc, 48'h0123456789AB);
    clr(); opc = `OPC_JCCui; cc = `CC_NE; src_sr_val = 48'h1; imm12 = 12'h9AB; step();
    chk("jcc_ne_taken", ow_branch_taken, 0);
    chk("jcc_ne_pc", ow_branch_pc, 0);
    clr(); opc = `OPC_BCCsr; cc = `CC_EQ; src_sr_val = 48'h1; pc = 48'h100; tgt_gp_val = 24'h00FFFE; step();
    chk("bsr_taken", ow_branch_taken, 1);
    chk("bsr_pc", ow_branch_pc, 48'h0000000100FE);
    clr(); opc = `OPC_BCCsr; cc = `CC_EQ; src_sr_val = 48'h1; pc = 48'h100; tgt_gp_val = 24'hFFFFF0; step();
    chk("bsr_neg_pc", ow_branch_pc, 48'h0000000000F0);
    clr(); opc = `OPC_BCCso; cc = `CC_EQ; src_sr_val = 48'h1; pc = 48'h200; imm12 = 12'd5; step();
    chk("bso_taken", ow_branch_taken, 1);
    chk("bso_pc", ow_branch_pc, 48'h205);
    clr(); opc = `OPC_BCCso; cc = `CC_EQ; src_sr_val = 48'h0; pc = 48'h200; imm12 = 12'd5; step();
    chk("bso_nt_taken", ow_branch_taken, 0);
    chk("bso_nt_pc", ow_branch_pc, 0);
    clr(); opc = `OPC_BCCso; cc = `CC_EQ; src_sr_val = 48'h1; pc = 48'h200; imm12 = 12'hFFF; step();
    chk("bso_neg_pc", ow_branch_pc, 48'h1FF);
    clr(); opc = `OPC_BCCso; cc = `CC_LT; src_sr_val = 48'h2; pc = 48'h300; imm12 = 12'd1; step();
    chk("lt_taken", ow_branch_taken, 1);
    chk("lt_pc", ow_branch_pc, 48'h301);
    clr(); opc = `OPC_BCCso; cc = `CC_GE; src_sr_val = 48'h2; pc = 48'h300; imm12 = 12'd1; step();
    chk("ge_taken", ow_branch_taken, 0);
    clr(); opc = `OPC_BALso; pc = 48'h1000; imm16 = 16'd12; step();
    chk("bal_taken", ow_branch_taken, 1);
    chk("bal_pc", ow_branch_pc, 48'h100C);
    clr(); opc = `OPC_BALso; pc = 48'h1000; imm16 = 16'hFFF8; step();
    chk("bal_neg_pc", ow_branch_pc, 48'h0FF8);
    clr(); opc = `OPC_BALso; pc = 48'h0; imm16 = 16'hFFFF; step();
    chk("bal_wrap_pc", ow_branch_pc, 48'hFFFFFFFFFFFF);
    clr(); opc = 8'h01; pc = 48'hABCD; instr = 24'h5A5A5A; src_gp_val = 24'h112233; src_ar_val = 48'h445566778899;
    src_sr_val = 48'h0A0B0C0D0E0F; tgt_ar_val = 48'h123456789ABC; tgt_gp = 4'd7; tgt_gp_we = 1'b1; tgt_sr_we = 1'b1; step();
    chk("alu_result", ow_result, 24'h112233);
    chk("alu_ar", ow_ar_result, 48'h445566778899);
    chk("alu_sr", ow_sr_result, 48'h0A0B0C0D0E0F);
    chk("alu_addr", ow_addr, 48'h123456789ABC);
    chk("alu_pc", ow_pc, 48'hABCD);
    chk("alu_instr", ow_instr, 24'h5A5A5A);
    chk("alu_tgt_gp", ow_tgt_gp, 4'd7);
    chk("alu_gp_we", ow_tgt_gp_we, 1);
    chk("alu_ar_we", ow_tgt_ar_we, 0);
    chk("alu_taken", ow_branch_taken, 0);
    clr(); opc = `OPC_BALso; pc = 48'h1000; imm16 = 16'd12; step();
    clr(); stall = 1'b1; opc = `OPC_LUIui; instr = 24'h0; imm12 = 12'hABC; pc = 48'h7777; step();
    chk("stall_taken", ow_branch_taken, 1);
    chk("stall_bpc", ow_branch_pc, 48'h100C);
    chk("stall_opc", ow_opc, `OPC_BALso);
    chk("stall_pc", ow_pc, 48'h1000);
    clr(); opc = `OPC_JCCui; imm12 = 12'h000; step();
    chk("stall_bank", ow_branch_pc, 48'h012345678000);
    clr(); opc = `OPC_BALso; pc = 48'h1000; imm16 = 16'd12; instr = 24'hFFFFFF; tgt_gp_we = 1'b1; tgt_sr_we = 1'b1;
    src_gp_val = 24'h999999; flush = 1'b1; step();
    chk("flush_taken", ow_branch_taken, 0);
    chk("flush_bpc", ow_branch_pc, 0);
    chk("flush_gp_we", ow_tgt_gp_we, 0);
    chk("flush_sr_we", ow_tgt_sr_we, 0);
    chk("flush_opc", ow_opc, 0);
    chk("flush_instr", ow_instr, 0);
    chk("flush_result", ow_result, 0);
    clr(); opc = `OPC_BALso; pc = 48'h1000; imm16 = 16'd12; step();
    clr(); opc = `OPC_LUIui; instr = 24'h0; imm12 = 12'hFFF; flush = 1'b1; stall = 1'b1; step();
    chk("flush_stall_taken", ow_branch_taken, 0);
    chk("flush_stall_opc", ow_opc, 0);
    clr(); opc = `OPC_JCCui; imm12 = 12'h001; step();
    chk("flush_bank", ow_branch_pc, 48'h012345678001);
    clr(); opc = `OPC_BALso; pc = 48'h2000; imm16 = 16'd1; flush = 1'b1; stall = 1'b1; rst = 1'b0; step();
    chk("rst_prio_taken", ow_branch_taken, 0);
    chk("rst_prio_bpc", ow_branch_pc, 0);
    clr(); opc = `OPC_JCCui; cc = `CC_AL; imm12 = 12'h001; step();
    chk("rst_bank_taken", ow_branch_taken, 1);
    chk("rst_bank_pc", ow_branch_pc, 48'h000000000001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
